// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared encodings for the data_ram load/store memory.
//   LEN_*  : req_len access-size codes
//   EXC_*  : rsp_exc exception cause codes
//   lane_mask() : byte-lane write enables for an access of a given size/offset
package data_ram_pkg;

  localparam logic [1:0] LEN_BYTE    = 2'b00;
  localparam logic [1:0] LEN_HALF    = 2'b01;
  localparam logic [1:0] LEN_WORD    = 2'b10;
  localparam logic [1:0] LEN_ILLEGAL = 2'b11;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_RANGE    = 2'b01;
  localparam logic [1:0] EXC_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_LEN      = 2'b11;

  // Lane k enabled means bank k (byte lane k, little-endian) is written.
  function automatic logic [3:0] lane_mask(input logic [1:0] len, input logic [1:0] off);
    logic [3:0] m;
    case (len)
      LEN_BYTE: m = 4'b0001 << off;
      LEN_HALF: m = 4'b0011 << off;
      default:  m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// ram_bank: single-port 8-bit synchronous RAM with registered read.
//   DEPTH  : number of bytes in the bank
//   LANE   : byte lane held by this bank (selects bytes from the flash image)
// Ports:
//   clk    in   clock
//   we     in   write enable (writes wdata to mem[addr])
//   re     in   read enable (loads rdata register from mem[addr]); rdata holds otherwise
//   addr   in   word index
//   wdata  in   write byte
//   rdata  out  registered read byte
// Optional: DATA_RAM_INIT_EN preloads the bank at time zero from the
// byte array flash_image[], filled in by the initial block below.
module ram_bank #(
  parameter int DEPTH = 1024,
  parameter int LANE  = 0,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

`ifdef DATA_RAM_INIT_EN
  // Flash image is byte-addressed; this bank takes every fourth byte.
  logic [7:0] flash_image [4*DEPTH];
  initial begin
    for (int j = 0; j < 4*DEPTH; j++) begin
      flash_image[j] = 8'h00;
    end
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = flash_image[4*i + LANE];
    end
  end
`else
  // Contents are undefined until written.
`endif

  // The read register only loads on an accepted read, so a stalled
  // response keeps its data regardless of later bank activity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_ram.sv
// data_ram: clocked, handshaked, byte-addressed data memory.
// Byte/half/word accesses, little-endian lanes, zero/sign-extended loads,
// coded exceptions for illegal length, out-of-range and misaligned accesses.
// Parameters:
//   ADDR_WIDTH : byte-address width (capacity 2**ADDR_WIDTH bytes), >= 3
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready = !rsp_valid | rsp_ready)
//   req_rw                1 = write, 0 = read
//   req_len               00 byte, 01 half, 10 word, 11 illegal
//   req_signed            sign-extend byte/half reads
//   req_addr, req_wdata   byte address, right-aligned write data
//   rsp_valid/rsp_ready   response handshake, held until consumed
//   rsp_rdata             right-aligned, extended read data (0 for writes/exceptions)
//   rsp_exc               00 none, 01 range, 10 misaligned, 11 illegal length
// Optional: DATA_RAM_INIT_EN preloads the banks from the flash image (see ram_bank).
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_len,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_exc
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  logic             accept;
  logic [1:0]       exc_now;
  logic [3:0]       lane_en;
  logic [31:0]      wdata_rep;
  logic [IDX_W-1:0] word_idx;
  logic             do_write;
  logic             do_read;
  logic [3:0][7:0]  bank_rdata;
  logic [31:0]      shifted;
  logic [31:0]      rdata_ext;

  logic       valid_q,  valid_d;
  logic [1:0] exc_q,    exc_d;
  logic       rd_q,     rd_d;
  logic [1:0] shift_q,  shift_d;
  logic [1:0] len_q,    len_d;
  logic       signed_q, signed_d;

  assign req_ready = !valid_q | rsp_ready;
  // A request seen while reset is asserted is never taken.
  assign accept    = req_valid & req_ready & rst_n;
  assign word_idx  = req_addr[ADDR_WIDTH-1:2];

  // Classification in priority order: length, range, alignment.
  always_comb begin
    exc_now = EXC_NONE;
    if (req_len == LEN_ILLEGAL) begin
      exc_now = EXC_LEN;
    end else if ((req_addr >> ADDR_WIDTH) != 32'd0) begin
      exc_now = EXC_RANGE;
    end else if ((req_len == LEN_HALF && req_addr[0]) ||
                 (req_len == LEN_WORD && req_addr[1:0] != 2'b00)) begin
      exc_now = EXC_MISALIGN;
    end
  end

  assign do_write = accept &  req_rw & (exc_now == EXC_NONE);
  assign do_read  = accept & !req_rw & (exc_now == EXC_NONE);
  assign lane_en  = lane_mask(req_len, req_addr[1:0]);

  // Replicate the right-aligned data so every enabled lane sees its byte.
  always_comb begin
    case (req_len)
      LEN_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      LEN_HALF: wdata_rep = {2{req_wdata[15:0]}};
      default:  wdata_rep = req_wdata;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    ram_bank #(
      .DEPTH (DEPTH),
      .LANE  (gi)
    ) u_bank (
      .clk   (clk),
      .we    (do_write & lane_en[gi]),
      .re    (do_read),
      .addr  (word_idx),
      .wdata (wdata_rep[8*gi +: 8]),
      .rdata (bank_rdata[gi])
    );
  end

  // Response register: capture on acceptance, drop when consumed.
  always_comb begin
    valid_d  = valid_q;
    exc_d    = exc_q;
    rd_d     = rd_q;
    shift_d  = shift_q;
    len_d    = len_q;
    signed_d = signed_q;
    if (accept) begin
      valid_d  = 1'b1;
      exc_d    = exc_now;
      rd_d     = do_read;
      shift_d  = req_addr[1:0];
      len_d    = req_len;
      signed_d = req_signed;
    end else if (rsp_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      exc_q    <= EXC_NONE;
      rd_q     <= 1'b0;
      shift_q  <= 2'b00;
      len_q    <= LEN_BYTE;
      signed_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      exc_q    <= exc_d;
      rd_q     <= rd_d;
      shift_q  <= shift_d;
      len_q    <= len_d;
      signed_q <= signed_d;
    end
  end

  // Extraction works on the registered bank outputs and the captured
  // offset/size/sign, so the data is valid in the response cycle.
  assign shifted = bank_rdata >> {shift_q, 3'b000};

  always_comb begin
    rdata_ext = 32'd0;
    if (rd_q) begin
      case (len_q)
        LEN_BYTE: rdata_ext = {{24{signed_q & shifted[7]}},  shifted[7:0]};
        LEN_HALF: rdata_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
        default:  rdata_ext = shifted;
      endcase
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_exc   = exc_q;
  assign rsp_rdata = rdata_ext;

endmodule
